// File: rtl/gpmc_sync_slave.sv
// GPMC synchronous slave: demuxes the muxed AD bus into address/data phases,
// issues one-cycle write/read strobes and drives read data back onto the AD bus.
module gpmc_sync_slave #(
  parameter int          ADDR_W       = 16,
  parameter int          RD_TIMEOUT   = 2,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic              gpmc_clk,
  input  logic              glbl_reset,
  input  logic [15:0]       gpmc_ad_in,
  output logic [15:0]       gpmc_ad_out,
  output logic              gpmc_ad_oe,
  input  logic              gpmc_advn,
  input  logic              gpmc_csn,
  input  logic              gpmc_wein,
  input  logic              gpmc_oen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr_en,
  output logic [15:0]       bus_wr_data,
  output logic              bus_rd_en,
  input  logic [15:0]       bus_rd_data,
  input  logic              bus_rd_valid,
  output logic              bus_timeout
);

  // state    | meaning
  // IDLE     | waiting for csn & advn low (address phase)
  // ADDR     | address captured, waiting for write or read data phase
  // RD_WAIT  | read strobe issued, waiting for bus_rd_valid or timeout
  // RD_DRIVE | read data held on the AD bus until csn rises
  // DONE     | write finished, waiting for csn to rise
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_DRIVE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [7:0] L_TIMEOUT = 8'(RD_TIMEOUT);

  logic [2:0]        r_state;
  logic [7:0]        r_cnt;
  logic              r_rd_flag;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [15:0]       r_wr_data;
  logic              r_rd_en;
  logic              r_timeout;
  logic [15:0]       r_ad_out;

  logic [15:0] w_word_addr;
  logic [7:0]  w_cnt_nxt;

  // Host drives byte addresses; the register space is word addressed.
  assign w_word_addr = {1'b0, gpmc_ad_in[15:1]};
  assign w_cnt_nxt   = r_cnt + 8'd1;

  always_ff @(posedge gpmc_clk or posedge glbl_reset) begin
    if (glbl_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_rd_flag <= 1'b0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= 16'd0;
      r_rd_en   <= 1'b0;
      r_timeout <= 1'b0;
      r_ad_out  <= 16'd0;
    end else begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!gpmc_csn && !gpmc_advn) begin
            r_addr  <= w_word_addr[ADDR_W-1:0];
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (gpmc_csn) begin
            r_state <= S_IDLE;
          end else if (!gpmc_wein) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= gpmc_ad_in;
            r_state   <= S_DONE;
          end else if (!gpmc_oen) begin
            r_rd_en   <= 1'b1;
            r_cnt     <= 8'd0;
            r_rd_flag <= 1'b1;
            r_state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (gpmc_csn) begin
            r_rd_flag <= 1'b0;
            r_ad_out  <= 16'd0;
            r_state   <= S_IDLE;
          end else if (bus_rd_valid) begin
            r_ad_out <= bus_rd_data;
            r_state  <= S_RD_DRIVE;
          end else if (w_cnt_nxt >= L_TIMEOUT) begin
            r_cnt     <= w_cnt_nxt;
            r_ad_out  <= TIMEOUT_DATA;
            r_timeout <= 1'b1;
            r_state   <= S_RD_DRIVE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RD_DRIVE: begin
          if (gpmc_csn) begin
            r_rd_flag <= 1'b0;
            r_ad_out  <= 16'd0;
            r_state   <= S_IDLE;
          end
        end
        S_DONE: begin
          if (gpmc_csn) r_state <= S_IDLE;
        end
        default: begin
          r_rd_flag <= 1'b0;
          r_ad_out  <= 16'd0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational gate so the bus is released the instant oen or csn rises.
  assign gpmc_ad_oe  = r_rd_flag & ~gpmc_oen & ~gpmc_csn;
  assign gpmc_ad_out = r_ad_out;
  assign bus_addr    = r_addr;
  assign bus_wr_en   = r_wr_en;
  assign bus_wr_data = r_wr_data;
  assign bus_rd_en   = r_rd_en;
  assign bus_timeout = r_timeout;

endmodule

// File: tb/tb_gpmc_sync_slave.sv
// Directed bench for gpmc_sync_slave: a per-cycle vector table plus hand-written
// sequences for reset-during-read and back-to-back writes.
module tb_gpmc_sync_slave;

  typedef struct {
    logic        csn, advn, wein, oen;
    logic [15:0] ad;
    logic        rdv;
    logic [15:0] rdd;
    logic        e_wr, e_rd, e_to, e_oe;
    logic [15:0] e_out, e_addr, e_wd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ad_in = 16'd0;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic        advn = 1'b1, csn = 1'b1, wein = 1'b1, oen = 1'b1;
  logic [15:0] addr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_data = 16'd0;
  logic        rd_valid = 1'b0;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_rd  = 0;

  vec_t vecs[24];

  gpmc_sync_slave dut (
    .gpmc_clk    (clk),
    .glbl_reset  (rst),
    .gpmc_ad_in  (ad_in),
    .gpmc_ad_out (ad_out),
    .gpmc_ad_oe  (ad_oe),
    .gpmc_advn   (advn),
    .gpmc_csn    (csn),
    .gpmc_wein   (wein),
    .gpmc_oen    (oen),
    .bus_addr    (addr),
    .bus_wr_en   (wr_en),
    .bus_wr_data (wr_data),
    .bus_rd_en   (rd_en),
    .bus_rd_data (rd_data),
    .bus_rd_valid(rd_valid),
    .bus_timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, a, w, o, input logic [15:0] d, input logic v,
                              input logic [15:0] rd, input logic ew, er, et, eo,
                              input logic [15:0] eout, eaddr, ewd);
    vec_t t;
    t.csn = c; t.advn = a; t.wein = w; t.oen = o; t.ad = d; t.rdv = v; t.rdd = rd;
    t.e_wr = ew; t.e_rd = er; t.e_to = et; t.e_oe = eo;
    t.e_out = eout; t.e_addr = eaddr; t.e_wd = ewd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on negedge, settle past the next posedge.
  task automatic cyc(input logic c, a, w, o, input logic [15:0] d, input logic v,
                     input logic [15:0] rd);
    @(negedge clk);
    csn = c; advn = a; wein = w; oen = o; ad_in = d; rd_valid = v; rd_data = rd;
    @(posedge clk);
    #1;
    if (wr_en) n_wr++;
    if (rd_en) n_rd++;
  endtask

  initial begin
    logic [15:0] d;

    vecs[0]  = mk(0,0,1,1,16'h0002,0,16'h0000, 0,0,0,0,16'h0000,16'h0001,16'h0000);
    vecs[1]  = mk(0,1,0,1,16'h4321,0,16'h0000, 1,0,0,0,16'h0000,16'h0001,16'h4321);
    vecs[2]  = mk(0,1,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,16'h0001,16'h4321);
    vecs[3]  = mk(1,1,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,16'h0001,16'h4321);
    vecs[4]  = mk(0,0,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,16'h0000,16'h4321);
    vecs[5]  = mk(0,1,1,0,16'h0000,0,16'h0000, 0,1,0,1,16'h0000,16'h0000,16'h4321);
    vecs[6]  = mk(0,1,1,0,16'h0000,1,16'h1234, 0,0,0,1,16'h1234,16'h0000,16'h4321);
    vecs[7]  = mk(0,1,1,0,16'h0000,0,16'h0000, 0,0,0,1,16'h1234,16'h0000,16'h4321);
    vecs[8]  = mk(0,1,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h1234,16'h0000,16'h4321);
    vecs[9]  = mk(1,1,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,16'h0000,16'h4321);
    vecs[10] = mk(0,0,1,1,16'h0004,0,16'h0000, 0,0,0,0,16'h0000,16'h0002,16'h4321);
    vecs[11] = mk(0,1,1,0,16'h0000,0,16'h0000, 0,1,0,1,16'h0000,16'h0002,16'h4321);
    vecs[12] = mk(0,1,1,0,16'h0000,0,16'h0000, 0,0,0,1,16'h0000,16'h0002,16'h4321);
    vecs[13] = mk(0,1,1,0,16'h0000,0,16'h0000, 0,0,1,1,16'hDEAD,16'h0002,16'h4321);
    vecs[14] = mk(0,1,1,0,16'h0000,0,16'h0000, 0,0,0,1,16'hDEAD,16'h0002,16'h4321);
    vecs[15] = mk(1,1,1,1,16'h0000,1,16'hBEEF, 0,0,0,0,16'h0000,16'h0002,16'h4321);
    vecs[16] = mk(0,0,1,1,16'h0010,0,16'h0000, 0,0,0,0,16'h0000,16'h0008,16'h4321);
    vecs[17] = mk(1,1,0,1,16'h5555,0,16'h0000, 0,0,0,0,16'h0000,16'h0008,16'h4321);
    vecs[18] = mk(0,0,1,1,16'h0020,0,16'h0000, 0,0,0,0,16'h0000,16'h0010,16'h4321);
    vecs[19] = mk(0,1,0,1,16'h7777,0,16'h0000, 1,0,0,0,16'h0000,16'h0010,16'h7777);
    vecs[20] = mk(1,1,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,16'h0010,16'h7777);
    vecs[21] = mk(0,0,1,1,16'h0030,0,16'h0000, 0,0,0,0,16'h0000,16'h0018,16'h7777);
    vecs[22] = mk(0,1,0,0,16'hAAAA,0,16'h0000, 1,0,0,0,16'h0000,16'h0018,16'hAAAA);
    vecs[23] = mk(1,1,1,1,16'h0000,0,16'h0000, 0,0,0,0,16'h0000,16'h0018,16'hAAAA);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {ad_out, ad_oe, wr_en, rd_en, timeout}, 32'd0);
    chk("rst_addr_data", {addr, wr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].csn, vecs[i].advn, vecs[i].wein, vecs[i].oen, vecs[i].ad,
          vecs[i].rdv, vecs[i].rdd);
      chk($sformatf("v%0d_wr_en", i),   {31'd0, wr_en},   {31'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_rd_en", i),   {31'd0, rd_en},   {31'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_timeout", i), {31'd0, timeout}, {31'd0, vecs[i].e_to});
      chk($sformatf("v%0d_ad_oe", i),   {31'd0, ad_oe},   {31'd0, vecs[i].e_oe});
      chk($sformatf("v%0d_ad_out", i),  {16'd0, ad_out},  {16'd0, vecs[i].e_out});
      chk($sformatf("v%0d_addr", i),    {16'd0, addr},    {16'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_wr_data", i), {16'd0, wr_data}, {16'd0, vecs[i].e_wd});
    end

    // Async reset while waiting for read data
    cyc(0,0,1,1,16'h0008,0,16'h0000);
    cyc(0,1,1,0,16'h0000,0,16'h0000);
    chk("rdwait_oe_before_rst", {31'd0, ad_oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_oe", {31'd0, ad_oe}, 32'd0);
    chk("async_rst_outs", {ad_out, wr_en, rd_en, timeout, 13'd0}, 32'd0);
    chk("async_rst_addr", {addr, wr_data}, 32'd0);
    cyc(1,1,1,1,16'h0000,0,16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Read of byte 0x0002 with valid on the 2nd cycle after the strobe
    cyc(0,0,1,1,16'h0002,0,16'h0000);
    chk("post_rst_addr", {16'd0, addr}, 32'h0001);
    cyc(0,1,1,0,16'h0000,0,16'h0000);
    chk("post_rst_rd_en", {31'd0, rd_en}, 32'd1);
    cyc(0,1,1,0,16'h0000,0,16'h0000);
    chk("post_rst_wait", {ad_out, 15'd0, timeout}, 32'd0);
    cyc(0,1,1,0,16'h0000,1,16'h5A5A);
    chk("post_rst_data", {16'd0, ad_out}, 32'h5A5A);
    chk("post_rst_no_to", {30'd0, timeout, ad_oe}, 32'd1);
    cyc(1,1,1,1,16'h0000,0,16'h0000);
    chk("post_rst_release", {15'd0, ad_oe, ad_out}, 32'd0);

    // Six back-to-back writes to byte 0x1000
    n_wr = 0;
    n_rd = 0;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      cyc(0,0,1,1,16'h1000,0,16'h0000);
      cyc(0,1,0,1,d,0,16'h0000);
      chk($sformatf("b2b%0d_wr_en", i), {31'd0, wr_en}, 32'd1);
      chk($sformatf("b2b%0d_data", i), {16'd0, wr_data}, {16'd0, d});
      chk($sformatf("b2b%0d_addr", i), {16'd0, addr}, 32'h0800);
      cyc(1,1,1,1,16'h0000,0,16'h0000);
    end
    chk("b2b_wr_count", n_wr, 6);
    chk("b2b_rd_count", n_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
